// File: rtl/bm_lpm_concat_packer.sv
// Packs RATIO consecutive IN_W-bit words into one registered wide word, with partial-group flush on in_last.
// Latency: out_valid rises the cycle after the input transfer that closes a group.
// Backpressure: while a packed word is held, in_ready follows out_ready, so streaming runs at full rate.
//
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   in_valid/in_ready         narrow input handshake; in_data word, in_last closes the group early
//   out_valid/out_ready       wide output handshake; out_data packed word (unused lanes 0),
//                             out_count valid lanes (1..RATIO), out_last group closed by in_last
module bm_lpm_concat_packer #(
    parameter  int IN_W      = 8,
    parameter  int RATIO     = 4,
    parameter  int MSB_FIRST = 1,
    localparam int OUT_W     = IN_W * RATIO,
    localparam int CW        = $clog2(RATIO + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_last
);

    typedef enum logic {
        ACC  = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    state_t           state, state_nxt;
    logic [OUT_W-1:0] acc, acc_nxt;
    logic [CW-1:0]    idx, idx_nxt;
    logic [OUT_W-1:0] data_nxt;
    logic [CW-1:0]    count_nxt;
    logic             last_nxt;
    logic [OUT_W-1:0] lane_word;
    logic             in_fire;
    logic             out_fire;
    logic             close_grp;
    int               lane_pos;

    // In FULL an input is only taken alongside the output transfer, so the
    // accepted word always lands in an empty accumulator as lane 0.
    assign in_ready  = !reset && ((state == ACC) || out_ready);
    assign out_valid = (state == FULL);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        lane_pos  = (MSB_FIRST != 0) ? (RATIO - 1 - int'(idx)) : int'(idx);
        lane_word = OUT_W'(in_data) << (lane_pos * IN_W);
        close_grp = in_last || (idx == LAST_LANE);

        state_nxt = state;
        acc_nxt   = acc;
        idx_nxt   = idx;
        data_nxt  = out_data;
        count_nxt = out_count;
        last_nxt  = out_last;

        if (in_fire) begin
            if (close_grp) begin
                // Load the output straight from the merged accumulator and
                // clear it so the next group starts with zeroed lanes.
                data_nxt  = acc | lane_word;
                count_nxt = idx + CW'(1);
                last_nxt  = in_last;
                acc_nxt   = '0;
                idx_nxt   = '0;
                state_nxt = FULL;
            end else begin
                acc_nxt   = acc | lane_word;
                idx_nxt   = idx + CW'(1);
                state_nxt = ACC;
            end
        end else if (out_fire) begin
            state_nxt = ACC;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ACC;
            acc       <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            idx       <= idx_nxt;
            out_data  <= data_nxt;
            out_count <= count_nxt;
            out_last  <= last_nxt;
        end
    end

endmodule

// File: tb/tb_bm_lpm_concat_packer.sv
module tb_bm_lpm_concat_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        rdy_m, rdy_l, vld_m, vld_l, last_m, last_l;
    logic [31:0] data_m, data_l;
    logic [2:0]  cnt_m, cnt_l;

    bm_lpm_concat_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1)) dut_m (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_m),
        .in_data(in_data), .in_last(in_last), .out_valid(vld_m), .out_ready(out_ready),
        .out_data(data_m), .out_count(cnt_m), .out_last(last_m)
    );

    bm_lpm_concat_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) dut_l (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_l),
        .in_data(in_data), .in_last(in_last), .out_valid(vld_l), .out_ready(out_ready),
        .out_data(data_l), .out_count(cnt_l), .out_last(last_l)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing: lane k of the group placed by lane-order rule.
    function automatic logic [31:0] pack(input logic [7:0] g[$], input bit msb);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < g.size(); k++) begin
            if (msb) r[(3-k)*8 +: 8] = g[k];
            else     r[k*8 +: 8]     = g[k];
        end
        return r;
    endfunction

    // Behavioural model: a queue of words in the current group and one
    // pending packed word.
    logic [7:0]  m_grp[$];
    bit          m_pending = 0;
    logic [31:0] m_data_m = '0, m_data_l = '0;
    logic [2:0]  m_count = '0;
    logic        m_last = 1'b0;
    bit          m_loaded = 0;
    int          n_acc = 0;

    logic [31:0] obs_m[$];
    logic [31:0] obs_l[$];
    logic [2:0]  obs_c[$];
    logic        obs_x[$];

    initial begin : compare
        logic exp_rdy;
        @(posedge clock);
        forever begin
            @(negedge clock);
            #2;
            exp_rdy = !reset && (!m_pending || out_ready);
            chk("in_ready_msb", 32'(rdy_m), 32'(exp_rdy));
            chk("in_ready_lsb", 32'(rdy_l), 32'(exp_rdy));
            chk("out_valid_msb", 32'(vld_m), 32'(m_pending));
            chk("out_valid_lsb", 32'(vld_l), 32'(m_pending));
            if (m_pending || !m_loaded) begin
                chk("out_data_msb", data_m, m_data_m);
                chk("out_data_lsb", data_l, m_data_l);
                chk("out_count_msb", 32'(cnt_m), 32'(m_count));
                chk("out_count_lsb", 32'(cnt_l), 32'(m_count));
                chk("out_last_msb", 32'(last_m), 32'(m_last));
                chk("out_last_lsb", 32'(last_l), 32'(m_last));
            end
            if (vld_m === 1'b1 && out_ready) begin
                obs_m.push_back(data_m);
                obs_l.push_back(data_l);
                obs_c.push_back(cnt_m);
                obs_x.push_back(last_m);
            end
            if (reset) begin
                m_pending = 0;
                m_loaded  = 0;
                m_grp.delete();
                m_data_m  = '0;
                m_data_l  = '0;
                m_count   = '0;
                m_last    = 1'b0;
            end else begin
                if (m_pending && out_ready) m_pending = 0;
                if (in_valid && exp_rdy) begin
                    n_acc++;
                    m_grp.push_back(in_data);
                    if (in_last || m_grp.size() == 4) begin
                        m_data_m  = pack(m_grp, 1);
                        m_data_l  = pack(m_grp, 0);
                        m_count   = 3'(m_grp.size());
                        m_last    = in_last;
                        m_pending = 1;
                        m_loaded  = 1;
                        m_grp.delete();
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l, input logic ordy, output int waits);
        waits = 0;
        @(negedge clock);
        in_valid = 1'b1; in_data = d; in_last = l; out_ready = ordy;
        #1;
        while (rdy_m !== 1'b1 && waits < 20) begin
            @(negedge clock);
            #1;
            waits++;
        end
        if (waits >= 20) chk("send_timeout", 32'(waits), 32'd0);
    endtask

    task automatic put(input logic [7:0] d, input logic l);
        int w;
        send(d, l, 1'b1, w);
    endtask

    task automatic idle(input logic ordy);
        @(negedge clock);
        in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom); out_ready = ordy;
    endtask

    task automatic clear_obs();
        obs_m.delete(); obs_l.delete(); obs_c.delete(); obs_x.delete();
    endtask

    task automatic expect_obs(input int i, input logic [31:0] dm, input logic [31:0] dl,
                              input logic [2:0] c, input logic x);
        if (obs_m.size() > i) begin
            chk("lit_data_msb", obs_m[i], dm);
            chk("lit_data_lsb", obs_l[i], dl);
            chk("lit_count", 32'(obs_c[i]), 32'(c));
            chk("lit_last", 32'(obs_x[i]), 32'(x));
        end else begin
            chk("lit_missing_output", 32'(obs_m.size()), 32'(i + 1));
        end
    endtask

    initial begin : stimulus
        int w;
        int wsum;
        int acc0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle(1'b1);

        // Full group, both lane orders.
        clear_obs();
        put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h44, 0);
        idle(1'b1); idle(1'b1); idle(1'b1);
        chk("grp1_outputs", 32'(obs_m.size()), 32'd1);
        expect_obs(0, 32'h11223344, 32'h44332211, 3'd4, 1'b0);

        // Partial flush then a full group.
        clear_obs();
        put(8'hAA, 0); put(8'hBB, 1);
        idle(1'b1);
        put(8'h01, 0); put(8'h02, 0); put(8'h03, 0); put(8'h04, 0);
        idle(1'b1); idle(1'b1);
        chk("flush_outputs", 32'(obs_m.size()), 32'd2);
        expect_obs(0, 32'hAABB0000, 32'h0000BBAA, 3'd2, 1'b1);
        expect_obs(1, 32'h01020304, 32'h04030201, 3'd4, 1'b0);

        // Backpressure: hold out_ready low with input pending, then release with 0x55.
        clear_obs();
        put(8'h61, 0); put(8'h62, 0); put(8'h63, 0); put(8'h64, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0; out_ready = 1'b0;
            #1;
            chk("bp_in_ready", 32'(rdy_m), 32'd0);
            chk("bp_data_stable", data_m, 32'h61626364);
        end
        send(8'h55, 0, 1'b1, w);
        chk("bp_release_wait", 32'(w), 32'd0);
        put(8'h56, 0); put(8'h57, 0); put(8'h58, 0);
        idle(1'b1); idle(1'b1);
        chk("bp_outputs", 32'(obs_m.size()), 32'd2);
        expect_obs(0, 32'h61626364, 32'h64636261, 3'd4, 1'b0);
        expect_obs(1, 32'h55565758, 32'h58575655, 3'd4, 1'b0);

        // Full-rate streaming.
        clear_obs();
        acc0 = n_acc;
        wsum = 0;
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 0, 1'b1, w);
            wsum += w;
        end
        idle(1'b1); idle(1'b1);
        chk("stream_waits", 32'(wsum), 32'd0);
        chk("stream_accepts", 32'(n_acc - acc0), 32'd8);
        chk("stream_outputs", 32'(obs_m.size()), 32'd2);
        expect_obs(0, 32'h01020304, 32'h04030201, 3'd4, 1'b0);
        expect_obs(1, 32'h05060708, 32'h08070605, 3'd4, 1'b0);

        // Reset mid-group discards the partial lanes.
        clear_obs();
        put(8'h11, 0); put(8'h22, 0);
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_out_valid", 32'(vld_m), 32'd0);
        chk("rst_out_data", data_m, 32'd0);
        chk("rst_out_count", 32'(cnt_m), 32'd0);
        chk("rst_out_last", 32'(last_m), 32'd0);
        chk("rst_in_ready", 32'(rdy_m), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        put(8'hA1, 0); put(8'hA2, 0); put(8'hA3, 0); put(8'hA4, 0);
        idle(1'b1); idle(1'b1);
        chk("rst_outputs", 32'(obs_m.size()), 32'd1);
        expect_obs(0, 32'hA1A2A3A4, 32'hA4A3A2A1, 3'd4, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            reset     = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (4) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
